// File: rtl/bcd_display_scheduler_pkg.sv
// Shared codes and FSM encoding for the signed BCD display scheduler.
package bcd_display_scheduler_pkg;

    localparam logic [3:0] DigMinus = 4'hA;
    localparam logic [3:0] DigBlank = 4'hF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StConv = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_shift_unit.sv
// Iterative double-dabble core: one add-3 / shift-left step per enabled clock.
module bcd_shift_unit #(
    parameter int unsigned Width  = 16,
    parameter int unsigned Digits = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [Width-1:0]      mag_i,
    input  logic                  step_i,
    output logic [4*Digits-1:0]   bcd_o
);

    localparam int unsigned SrW = 4 * Digits + Width;

    logic [SrW-1:0] sr_q, sr_d, adj, shifted;

    always_comb begin
        adj = sr_q;
        for (int i = 0; i < int'(Digits); i++) begin
            if (sr_q[Width+4*i +: 4] > 4'd4) begin
                adj[Width+4*i +: 4] = sr_q[Width+4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj[SrW-2:0], 1'b0};
        sr_d    = sr_q;
        if (load_i) begin
            sr_d = {{(4*Digits){1'b0}}, mag_i};
        end else if (step_i) begin
            sr_d = shifted;
        end
    end

    // Post-step digits, so the owner can commit the final iteration at the same edge.
    assign bcd_o = shifted[SrW-1 -: 4*Digits];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/bcd_display_scheduler.sv
// Signed product to BCD conversion sequencer with scrollable multiplexed 4-digit display.
module bcd_display_scheduler
    import bcd_display_scheduler_pkg::*;
#(
    parameter int unsigned Width       = 16,
    parameter int unsigned Digits      = 5,
    parameter int unsigned RefreshBits = 18
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [Width-1:0]      product_i,
    input  logic                  scroll_left_i,
    input  logic                  scroll_right_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*Digits-1:0]   bcd_o,
    output logic                  sign_o,
    output logic [1:0]            scroll_pos_o,
    output logic [3:0]            anode_o,
    output logic [3:0]            digit_code_o
);

    localparam int unsigned CntW   = $clog2(Width + 1);
    localparam logic [1:0]  MaxPos = 2'(Digits - 3);

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   sign_lat_q, sign_lat_d;
    logic [4*Digits-1:0]    bcd_q, bcd_d, bcd_step;
    logic                   sign_q, sign_d;
    logic [1:0]             scroll_q, scroll_d;
    logic [RefreshBits-1:0] refresh_q, refresh_d;
    logic [Width-1:0]       mag;
    logic                   load, step, last;
    logic [1:0]             slot;
    logic [2:0]             digit_idx;

    assign mag  = product_i[Width-1] ? (~product_i + Width'(1)) : product_i;
    assign last = (cnt_q == CntW'(Width - 1));

    bcd_shift_unit #(
        .Width  (Width),
        .Digits (Digits)
    ) u_shift (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (load),
        .mag_i  (mag),
        .step_i (step),
        .bcd_o  (bcd_step)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StConv;
            StConv:  if (last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o = (state_q != StIdle);
        done_o = (state_q == StDone);
        load   = (state_q == StIdle) && start_i;
        step   = (state_q == StConv);
    end

    always_comb begin
        cnt_d      = cnt_q;
        sign_lat_d = sign_lat_q;
        bcd_d      = bcd_q;
        sign_d     = sign_q;
        scroll_d   = scroll_q;
        refresh_d  = refresh_q + RefreshBits'(1);
        if (load) begin
            cnt_d      = '0;
            sign_lat_d = product_i[Width-1] && (mag != '0);
        end
        if (step) begin
            cnt_d = cnt_q + CntW'(1);
            if (last) begin
                bcd_d  = bcd_step;
                sign_d = sign_lat_q;
            end
        end
        if (state_q == StDone) begin
            scroll_d = '0;
        end else if (scroll_left_i && !scroll_right_i && scroll_q < MaxPos) begin
            scroll_d = scroll_q + 2'd1;
        end else if (scroll_right_i && !scroll_left_i && scroll_q != 2'd0) begin
            scroll_d = scroll_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            sign_lat_q <= 1'b0;
            bcd_q      <= '0;
            sign_q     <= 1'b0;
            scroll_q   <= '0;
            refresh_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            sign_lat_q <= sign_lat_d;
            bcd_q      <= bcd_d;
            sign_q     <= sign_d;
            scroll_q   <= scroll_d;
            refresh_q  <= refresh_d;
        end
    end

    // Slot 3 is the sign position; slots 0..2 are a window starting at scroll_q.
    always_comb begin
        slot         = refresh_q[RefreshBits-1 -: 2];
        anode_o      = ~(4'b0001 << slot);
        digit_idx    = {1'b0, scroll_q} + {1'b0, slot};
        digit_code_o = bcd_q[4*digit_idx +: 4];
        if (slot == 2'd3) begin
            digit_code_o = sign_q ? DigMinus : DigBlank;
        end
    end

    assign bcd_o        = bcd_q;
    assign sign_o       = sign_q;
    assign scroll_pos_o = scroll_q;

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Directed self-checking bench for bcd_display_scheduler (short refresh counter).
module tb_bcd_display_scheduler;

    localparam int RB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] product;
    logic        scroll_l;
    logic        scroll_r;
    logic        busy_o;
    logic        done_o;
    logic [19:0] bcd_o;
    logic        sign_o;
    logic [1:0]  scroll_pos_o;
    logic [3:0]  anode_o;
    logic [3:0]  digit_code_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    bcd_display_scheduler #(
        .Width       (16),
        .Digits      (5),
        .RefreshBits (RB)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .product_i      (product),
        .scroll_left_i  (scroll_l),
        .scroll_right_i (scroll_r),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .bcd_o          (bcd_o),
        .sign_o         (sign_o),
        .scroll_pos_o   (scroll_pos_o),
        .anode_o        (anode_o),
        .digit_code_o   (digit_code_o)
    );

    always #5 clk = ~clk;

    // Start a conversion and observe 20 samples; optionally re-pulse start mid-flight.
    task automatic run_conv(input logic [15:0] prod, input logic [19:0] prev_bcd,
                            input int inj_cyc, input logic [15:0] inj_prod,
                            output int busy_cnt, output int done_cyc,
                            output int done_cnt, output int hold_bad);
        busy_cnt = 0; done_cyc = 0; done_cnt = 0; hold_bad = 0;
        start   = 1'b1;
        product = prod;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy_o) busy_cnt++;
            if (done_o) begin done_cnt++; done_cyc = k; end
            if (k <= 16 && bcd_o !== prev_bcd) hold_bad++;
            start = 1'b0;
            if (k == inj_cyc) begin start = 1'b1; product = inj_prod; end
        end
    endtask

    // Wait (bounded) for the anode of slot k and capture its code.
    task automatic read_slot(input int k, output logic [3:0] code, output bit found);
        logic [3:0] want;
        want  = ~(4'b0001 << k);
        found = 1'b0;
        code  = 4'h0;
        for (int i = 0; i < 64; i++) begin
            if (anode_o === want) begin
                code  = digit_code_o;
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; product = '0; scroll_l = 1'b0; scroll_r = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (anode_o !== 4'b1110) $display("FAIL reset_anode: got %b want 1110", anode_o); else pass_cnt++;
        total_cnt++; if (digit_code_o !== 4'h0) $display("FAIL reset_code: got %h want 0", digit_code_o); else pass_cnt++;
        total_cnt++; if (busy_o !== 1'b0 || done_o !== 1'b0) $display("FAIL reset_busy_done: got %b%b want 00", busy_o, done_o); else pass_cnt++;
        total_cnt++; if (bcd_o !== 20'h0 || sign_o !== 1'b0 || scroll_pos_o !== 2'd0) $display("FAIL reset_regs: got bcd %h sign %b pos %0d want 0 0 0", bcd_o, sign_o, scroll_pos_o); else pass_cnt++;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        total_cnt++; if (busy_o !== 1'b0 || bcd_o !== 20'h0) $display("FAIL idle_hold: got busy %b bcd %h want 0 0", busy_o, bcd_o); else pass_cnt++;
    endtask

    task automatic test_conv_1234();
        int bc, dc, dn, hb;
        logic [3:0] c;
        bit f;
        run_conv(16'h04D2, 20'h0, 0, 16'h0, bc, dc, dn, hb);
        total_cnt++; if (bc !== 17) $display("FAIL c1234_busy_cycles: got %0d want 17", bc); else pass_cnt++;
        total_cnt++; if (dc !== 17 || dn !== 1) $display("FAIL c1234_done: got cyc %0d cnt %0d want 17 1", dc, dn); else pass_cnt++;
        total_cnt++; if (hb !== 0) $display("FAIL c1234_hold: got %0d changes want 0", hb); else pass_cnt++;
        total_cnt++; if (bcd_o !== 20'h01234 || sign_o !== 1'b0) $display("FAIL c1234_result: got %h sign %b want 01234 0", bcd_o, sign_o); else pass_cnt++;
        read_slot(3, c, f);
        total_cnt++; if (!f || c !== 4'hF) $display("FAIL c1234_slot3: got %h found %b want F", c, f); else pass_cnt++;
        read_slot(2, c, f);
        total_cnt++; if (!f || c !== 4'h2) $display("FAIL c1234_slot2: got %h found %b want 2", c, f); else pass_cnt++;
        read_slot(1, c, f);
        total_cnt++; if (!f || c !== 4'h3) $display("FAIL c1234_slot1: got %h found %b want 3", c, f); else pass_cnt++;
        read_slot(0, c, f);
        total_cnt++; if (!f || c !== 4'h4) $display("FAIL c1234_slot0: got %h found %b want 4", c, f); else pass_cnt++;
    endtask

    task automatic test_negative();
        int bc, dc, dn, hb;
        logic [3:0] c;
        bit f;
        run_conv(16'hFFFF, 20'h01234, 0, 16'h0, bc, dc, dn, hb);
        total_cnt++; if (bcd_o !== 20'h00001 || sign_o !== 1'b1) $display("FAIL neg1_result: got %h sign %b want 00001 1", bcd_o, sign_o); else pass_cnt++;
        run_conv(16'h8000, 20'h00001, 0, 16'h0, bc, dc, dn, hb);
        total_cnt++; if (bcd_o !== 20'h32768 || sign_o !== 1'b1) $display("FAIL min_result: got %h sign %b want 32768 1", bcd_o, sign_o); else pass_cnt++;
        total_cnt++; if (dc !== 17 || hb !== 0) $display("FAIL min_timing: got done %0d hold %0d want 17 0", dc, hb); else pass_cnt++;
        read_slot(3, c, f);
        total_cnt++; if (!f || c !== 4'hA) $display("FAIL min_slot3: got %h found %b want A", c, f); else pass_cnt++;
    endtask

    task automatic test_scroll();
        logic [1:0] exp_l [3];
        logic [1:0] exp_r [3];
        logic [3:0] c;
        bit f;
        exp_l = '{2'd1, 2'd2, 2'd2};
        exp_r = '{2'd1, 2'd0, 2'd0};
        for (int i = 0; i < 3; i++) begin
            scroll_l = 1'b1; @(negedge clk); scroll_l = 1'b0;
            total_cnt++; if (scroll_pos_o !== exp_l[i]) $display("FAIL scroll_left_%0d: got %0d want %0d", i, scroll_pos_o, exp_l[i]); else pass_cnt++;
        end
        read_slot(2, c, f);
        total_cnt++; if (!f || c !== 4'h3) $display("FAIL scroll_slot2: got %h found %b want 3", c, f); else pass_cnt++;
        read_slot(1, c, f);
        total_cnt++; if (!f || c !== 4'h2) $display("FAIL scroll_slot1: got %h found %b want 2", c, f); else pass_cnt++;
        read_slot(0, c, f);
        total_cnt++; if (!f || c !== 4'h7) $display("FAIL scroll_slot0: got %h found %b want 7", c, f); else pass_cnt++;
        scroll_l = 1'b1; scroll_r = 1'b1; @(negedge clk); scroll_l = 1'b0; scroll_r = 1'b0;
        total_cnt++; if (scroll_pos_o !== 2'd2) $display("FAIL scroll_both: got %0d want 2", scroll_pos_o); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            scroll_r = 1'b1; @(negedge clk); scroll_r = 1'b0;
            total_cnt++; if (scroll_pos_o !== exp_r[i]) $display("FAIL scroll_right_%0d: got %0d want %0d", i, scroll_pos_o, exp_r[i]); else pass_cnt++;
        end
        scroll_l = 1'b1; @(negedge clk); @(negedge clk); scroll_l = 1'b0;
        total_cnt++; if (scroll_pos_o !== 2'd2) $display("FAIL scroll_preconv: got %0d want 2", scroll_pos_o); else pass_cnt++;
    endtask

    task automatic test_busy_ignore();
        int bc, dc, dn, hb;
        logic [3:0] c;
        bit f;
        run_conv(16'h0000, 20'h32768, 4, 16'h0063, bc, dc, dn, hb);
        total_cnt++; if (bc !== 17 || dn !== 1 || dc !== 17) $display("FAIL ignore_timing: got busy %0d done %0d@%0d want 17 1@17", bc, dn, dc); else pass_cnt++;
        total_cnt++; if (bcd_o !== 20'h0 || sign_o !== 1'b0) $display("FAIL ignore_result: got %h sign %b want 00000 0", bcd_o, sign_o); else pass_cnt++;
        total_cnt++; if (scroll_pos_o !== 2'd0) $display("FAIL done_scroll_clear: got %0d want 0", scroll_pos_o); else pass_cnt++;
        read_slot(3, c, f);
        total_cnt++; if (!f || c !== 4'hF) $display("FAIL zero_slot3: got %h found %b want F", c, f); else pass_cnt++;
        run_conv(16'h0063, 20'h0, 0, 16'h0, bc, dc, dn, hb);
        total_cnt++; if (bcd_o !== 20'h00099 || sign_o !== 1'b0) $display("FAIL c99_result: got %h sign %b want 00099 0", bcd_o, sign_o); else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int bc, dc, dn, hb;
        int done_seen;
        start = 1'b1; product = 16'h1111;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        total_cnt++; if (busy_o !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", busy_o); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        total_cnt++; if (busy_o !== 1'b0 || done_o !== 1'b0 || bcd_o !== 20'h0) $display("FAIL midrst_clear: got busy %b done %b bcd %h want 0 0 00000", busy_o, done_o, bcd_o); else pass_cnt++;
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_o || busy_o) done_seen++;
        end
        total_cnt++; if (done_seen !== 0) $display("FAIL midrst_no_done: got %0d active cycles want 0", done_seen); else pass_cnt++;
        run_conv(16'h10E1, 20'h0, 0, 16'h0, bc, dc, dn, hb);
        total_cnt++; if (bcd_o !== 20'h04321 || dc !== 17) $display("FAIL midrst_reconv: got %h done@%0d want 04321 17", bcd_o, dc); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_conv_1234();
        test_negative();
        test_scroll();
        test_busy_ignore();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
